// File: rtl/basilisk_writeback.sv
// -----------------------------------------------------------------------------
// basilisk_writeback
//   Consumer end of the basilisk FPU result streams. Four producers (mult, add,
//   sqrt, divide) each offer one result per cycle on a valid/ready stream. One
//   producer is granted per cycle, round-robin. The granted result is rounded to
//   IEEE-754 single and written through the single FP register-file write port.
//   The register file never stalls, so the granted source is always accepted
//   in the same cycle.
//
//   Result payload (basilisk_result_t, 35 bits):
//     [34]    sign
//     [33:26] biased exponent
//     [25:3]  23-bit fraction
//     [2:0]   guard, round, sticky
//
// Parameters
//   OUTPUT_REGISTER_MODE  0: wb_* come from stage 1 through the rounder (latency 1)
//                         1: rounded result is registered in stage 2 (latency 2)
//
// Ports
//   clk, rst                     clock, async active-high reset
//   <src>_result_command_valid   producer has a result
//   <src>_result_command_ready   producer's result is taken this cycle
//   <src>_result_command_dest_reg_addr  destination f-register
//   <src>_result_command_result  unrounded result payload
//     <src> = mult (0), add (1), sqrt (2), divide (3)
//   wb_enable   single-cycle register-file write strobe
//   wb_addr     destination register
//   wb_data     rounded single-precision value
//   wb_source   index of the producing unit
// -----------------------------------------------------------------------------
module basilisk_writeback #(
  parameter int OUTPUT_REGISTER_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_result_command_valid,
  output logic        mult_result_command_ready,
  input  logic [4:0]  mult_result_command_dest_reg_addr,
  input  logic [34:0] mult_result_command_result,
  input  logic        add_result_command_valid,
  output logic        add_result_command_ready,
  input  logic [4:0]  add_result_command_dest_reg_addr,
  input  logic [34:0] add_result_command_result,
  input  logic        sqrt_result_command_valid,
  output logic        sqrt_result_command_ready,
  input  logic [4:0]  sqrt_result_command_dest_reg_addr,
  input  logic [34:0] sqrt_result_command_result,
  input  logic        divide_result_command_valid,
  output logic        divide_result_command_ready,
  input  logic [4:0]  divide_result_command_dest_reg_addr,
  input  logic [34:0] divide_result_command_result,
  output logic        wb_enable,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_source
);

  // Round to nearest, ties to even. Adding the increment across {exponent,
  // fraction} lets a fraction carry bump the exponent, and a carry out of
  // exponent 254 lands exactly on infinity. Inf/NaN pass through untouched.
  function automatic logic [31:0] fpu_operations_round(input logic [34:0] r);
    logic        inc;
    logic [30:0] mag;
    inc = 1'b0;
    mag = {r[33:26], r[25:3]};
    if (r[33:26] != 8'hFF) begin
      inc = r[2] & (r[1] | r[0] | r[3]);
      mag = {r[33:26], r[25:3]} + {30'd0, inc};
    end else begin
      inc = 1'b0;
    end
    return {r[34], mag};
  endfunction

  logic [3:0]  valid_s;
  logic [4:0]  dest_s   [4];
  logic [34:0] result_s [4];
  logic [3:0]  ready_s;
  logic [1:0]  ptr_r;
  logic [1:0]  cand_s;
  logic [1:0]  grant_idx_s;
  logic        grant_any_s;

  logic        s1_valid_r;
  logic [4:0]  s1_dest_r;
  logic [34:0] s1_result_r;
  logic [1:0]  s1_src_r;

  assign valid_s     = {divide_result_command_valid, sqrt_result_command_valid,
                        add_result_command_valid, mult_result_command_valid};
  assign dest_s[0]   = mult_result_command_dest_reg_addr;
  assign dest_s[1]   = add_result_command_dest_reg_addr;
  assign dest_s[2]   = sqrt_result_command_dest_reg_addr;
  assign dest_s[3]   = divide_result_command_dest_reg_addr;
  assign result_s[0] = mult_result_command_result;
  assign result_s[1] = add_result_command_result;
  assign result_s[2] = sqrt_result_command_result;
  assign result_s[3] = divide_result_command_result;

  // Round-robin search: first valid source at or after the pointer, wrapping 3->0.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = ptr_r;
    cand_s      = ptr_r;
    for (int i = 0; i < 4; i++) begin
      cand_s = ptr_r + 2'(i);
      if (!grant_any_s && valid_s[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
      end
    end
  end

  // One-hot ready on the granted source only.
  always_comb begin
    if (grant_any_s) begin
      ready_s = 4'b0001 << grant_idx_s;
    end else begin
      ready_s = 4'b0000;
    end
  end

  assign mult_result_command_ready   = ready_s[0];
  assign add_result_command_ready    = ready_s[1];
  assign sqrt_result_command_ready   = ready_s[2];
  assign divide_result_command_ready = ready_s[3];

  // Pointer moves past the source just served; holds when nothing is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (grant_any_s) begin
      ptr_r <= grant_idx_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Stage 1: valid every cycle, payload only on a transfer so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_dest_r   <= 5'd0;
      s1_result_r <= 35'd0;
      s1_src_r    <= 2'd0;
    end else begin
      s1_valid_r <= grant_any_s;
      if (grant_any_s) begin
        s1_dest_r   <= dest_s[grant_idx_s];
        s1_result_r <= result_s[grant_idx_s];
        s1_src_r    <= grant_idx_s;
      end else begin
        s1_dest_r   <= s1_dest_r;
        s1_result_r <= s1_result_r;
        s1_src_r    <= s1_src_r;
      end
    end
  end

  generate
    if (OUTPUT_REGISTER_MODE != 0) begin : g_out_reg
      logic        s2_valid_r;
      logic [4:0]  s2_dest_r;
      logic [31:0] s2_data_r;
      logic [1:0]  s2_src_r;

      // Stage 2: registered rounded result; payload holds between writes.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_r <= 1'b0;
          s2_dest_r  <= 5'd0;
          s2_data_r  <= 32'd0;
          s2_src_r   <= 2'd0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_dest_r <= s1_dest_r;
            s2_data_r <= fpu_operations_round(s1_result_r);
            s2_src_r  <= s1_src_r;
          end else begin
            s2_dest_r <= s2_dest_r;
            s2_data_r <= s2_data_r;
            s2_src_r  <= s2_src_r;
          end
        end
      end

      assign wb_enable = s2_valid_r;
      assign wb_addr   = s2_dest_r;
      assign wb_data   = s2_data_r;
      assign wb_source = s2_src_r;
    end else begin : g_out_comb
      // Stage 1 payload already holds between transfers, and rounding a reset
      // payload of zero gives zero, so the outputs behave as registered ones.
      assign wb_enable = s1_valid_r;
      assign wb_addr   = s1_dest_r;
      assign wb_data   = fpu_operations_round(s1_result_r);
      assign wb_source = s1_src_r;
    end
  endgenerate

endmodule

// File: tb/tb_basilisk_writeback.sv
module tb_basilisk_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  vld;
  logic [4:0]  dst [4];
  logic [34:0] res [4];
  logic [3:0]  rdy1, rdy0;
  logic        en1, en0;
  logic [4:0]  a1, a0;
  logic [31:0] d1, d0;
  logic [1:0]  s1, s0;

  basilisk_writeback #(.OUTPUT_REGISTER_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .mult_result_command_valid(vld[0]), .mult_result_command_ready(rdy1[0]),
    .mult_result_command_dest_reg_addr(dst[0]), .mult_result_command_result(res[0]),
    .add_result_command_valid(vld[1]), .add_result_command_ready(rdy1[1]),
    .add_result_command_dest_reg_addr(dst[1]), .add_result_command_result(res[1]),
    .sqrt_result_command_valid(vld[2]), .sqrt_result_command_ready(rdy1[2]),
    .sqrt_result_command_dest_reg_addr(dst[2]), .sqrt_result_command_result(res[2]),
    .divide_result_command_valid(vld[3]), .divide_result_command_ready(rdy1[3]),
    .divide_result_command_dest_reg_addr(dst[3]), .divide_result_command_result(res[3]),
    .wb_enable(en1), .wb_addr(a1), .wb_data(d1), .wb_source(s1));

  basilisk_writeback #(.OUTPUT_REGISTER_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .mult_result_command_valid(vld[0]), .mult_result_command_ready(rdy0[0]),
    .mult_result_command_dest_reg_addr(dst[0]), .mult_result_command_result(res[0]),
    .add_result_command_valid(vld[1]), .add_result_command_ready(rdy0[1]),
    .add_result_command_dest_reg_addr(dst[1]), .add_result_command_result(res[1]),
    .sqrt_result_command_valid(vld[2]), .sqrt_result_command_ready(rdy0[2]),
    .sqrt_result_command_dest_reg_addr(dst[2]), .sqrt_result_command_result(res[2]),
    .divide_result_command_valid(vld[3]), .divide_result_command_ready(rdy0[3]),
    .divide_result_command_dest_reg_addr(dst[3]), .divide_result_command_result(res[3]),
    .wb_enable(en0), .wb_addr(a0), .wb_data(d0), .wb_source(s0));

  // Payloads {sign, exp, fraction, grs}
  localparam logic [34:0] SQ = {1'b0, 8'h7F, 23'h3504F3, 3'b001}; // sqrt(2.0)
  localparam logic [34:0] DV = {1'b0, 8'h7F, 23'h400000, 3'b000}; // 3.0/2.0
  localparam logic [34:0] AD = {1'b0, 8'h82, 23'h000000, 3'b000}; // 4+4
  localparam logic [34:0] ML = {1'b0, 8'h83, 23'h000000, 3'b000}; // 4*4

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
  } wr_t;

  int  ptr;
  int  cyc = 0;
  wr_t q1[$];
  wr_t q0[$];
  wr_t last1, last0;

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] model_round(input logic [34:0] r);
    longint unsigned e, q, rem, mag;
    e = r[33:26]; q = r[25:3]; rem = r[2:0];
    if (e == 255) return {r[34], 8'hFF, r[25:3]};
    if (rem > 4 || (rem == 4 && q % 2 == 1)) q = q + 1;
    mag = e * (64'd1 << 23) + q;
    return {r[34], mag[30:0]};
  endfunction

  task automatic model_reset();
    ptr = 0;
    q1.delete(); q0.delete();
    last1 = '{0, 5'd0, 32'd0, 2'd0};
    last0 = '{0, 5'd0, 32'd0, 2'd0};
  endtask

  task automatic step_sample(output int g);
    wr_t  w;
    logic e;
    logic [3:0] exp_rdy;
    @(negedge clk);
    g = model_grant(vld, ptr);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("ready_m1", 32'(rdy1), 32'(exp_rdy));
    chk("ready_m0", 32'(rdy0), 32'(exp_rdy));
    e = 1'b0;
    if (q1.size() > 0 && q1[0].cyc + 2 == cyc) begin last1 = q1.pop_front(); e = 1'b1; end
    chk("m1_en", 32'(en1), 32'(e));
    chk("m1_addr", 32'(a1), 32'(last1.addr));
    chk("m1_data", d1, last1.data);
    chk("m1_src", 32'(s1), 32'(last1.src));
    e = 1'b0;
    if (q0.size() > 0 && q0[0].cyc + 1 == cyc) begin last0 = q0.pop_front(); e = 1'b1; end
    chk("m0_en", 32'(en0), 32'(e));
    chk("m0_addr", 32'(a0), 32'(last0.addr));
    chk("m0_data", d0, last0.data);
    chk("m0_src", 32'(s0), 32'(last0.src));
    if (g >= 0) begin
      w.cyc = cyc; w.addr = dst[g]; w.data = model_round(res[g]); w.src = 2'(g);
      q1.push_back(w); q0.push_back(w);
    end
  endtask

  task automatic step_advance(input int g);
    @(posedge clk); #1;
    cyc++;
    if (g >= 0) ptr = (g + 1) % 4;
  endtask

  task automatic idle_steps(input int n);
    int g;
    vld = 4'b0000;
    for (int i = 0; i < n; i++) begin step_sample(g); step_advance(g); end
  endtask

  // Caller is #1 past a rising edge (or at time 0).
  task automatic do_reset();
    rst = 1'b1;
    vld = 4'b0000;
    model_reset();
    @(negedge clk);
    chk("rst_en_m1", 32'(en1), 32'd0);
    chk("rst_en_m0", 32'(en0), 32'd0);
    chk("rst_data_m1", d1, 32'd0);
    chk("rst_addr_src_m1", 32'({a1, s1}), 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic        rst_before;
    logic        pset;       // 0: dests 8,8,5,6   1: mult->1, div->2
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic        exp_en;     // mode-1 outputs seen in this row
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(logic r, logic p, logic [3:0] v, logic [3:0] rd,
                              logic e, logic [4:0] a, logic [31:0] d, logic [1:0] s);
    vec_t t;
    t.rst_before = r; t.pset = p; t.valid = v; t.exp_ready = rd;
    t.exp_en = e; t.exp_addr = a; t.exp_data = d; t.exp_src = s;
    return t;
  endfunction

  int g;

  initial begin
    vld = 4'b0000;
    for (int j = 0; j < 4; j++) begin dst[j] = 5'd0; res[j] = 35'd0; end

    // sqrt, divide, add alone
    tbl[0]  = mk(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 5'd0, 32'h00000000, 2'd0);
    tbl[1]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0, 32'h00000000, 2'd0);
    tbl[2]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd5, 32'h3FB504F3, 2'd2);
    tbl[3]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd5, 32'h3FB504F3, 2'd2);
    tbl[4]  = mk(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 5'd5, 32'h3FB504F3, 2'd2);
    tbl[5]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd5, 32'h3FB504F3, 2'd2);
    tbl[6]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd6, 32'h3FC00000, 2'd3);
    tbl[7]  = mk(1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 5'd6, 32'h3FC00000, 2'd3);
    tbl[8]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd6, 32'h3FC00000, 2'd3);
    tbl[9]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd8, 32'h41000000, 2'd1);
    // all four valid out of reset, each held until served
    tbl[10] = mk(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0, 5'd0, 32'h00000000, 2'd0);
    tbl[11] = mk(1'b0, 1'b0, 4'b1110, 4'b0010, 1'b0, 5'd0, 32'h00000000, 2'd0);
    tbl[12] = mk(1'b0, 1'b0, 4'b1100, 4'b0100, 1'b1, 5'd8, 32'h41800000, 2'd0);
    tbl[13] = mk(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 5'd8, 32'h41000000, 2'd1);
    tbl[14] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd5, 32'h3FB504F3, 2'd2);
    tbl[15] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd6, 32'h3FC00000, 2'd3);
    tbl[16] = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd6, 32'h3FC00000, 2'd3);
    // sources 0 and 3 continuously valid for 8 cycles
    tbl[17] = mk(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0, 5'd6, 32'h3FC00000, 2'd3);
    tbl[18] = mk(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b0, 5'd6, 32'h3FC00000, 2'd3);
    tbl[19] = mk(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1, 5'd1, 32'h41800000, 2'd0);
    tbl[20] = mk(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b1, 5'd2, 32'h3FC00000, 2'd3);
    tbl[21] = mk(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1, 5'd1, 32'h41800000, 2'd0);
    tbl[22] = mk(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b1, 5'd2, 32'h3FC00000, 2'd3);
    tbl[23] = mk(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b1, 5'd1, 32'h41800000, 2'd0);
    tbl[24] = mk(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b1, 5'd2, 32'h3FC00000, 2'd3);
    tbl[25] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 5'd1, 32'h41800000, 2'd0);
    tbl[26] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 5'd2, 32'h3FC00000, 2'd3);
    tbl[27] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'd2, 32'h3FC00000, 2'd3);

    do_reset();

    for (int i = 0; i < 28; i++) begin
      if (tbl[i].rst_before) do_reset();
      vld = tbl[i].valid;
      res[0] = ML; res[1] = AD; res[2] = SQ; res[3] = DV;
      if (tbl[i].pset) begin dst[0] = 5'd1; dst[1] = 5'd0; dst[2] = 5'd0; dst[3] = 5'd2; end
      else             begin dst[0] = 5'd8; dst[1] = 5'd8; dst[2] = 5'd5; dst[3] = 5'd6; end
      step_sample(g);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy1), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_en", i), 32'(en1), 32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_addr", i), 32'(a1), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_data", i), d1, tbl[i].exp_data);
      chk($sformatf("tbl%0d_src", i), 32'(s1), 32'(tbl[i].exp_src));
      // the latency-1 build shows one row earlier what the latency-2 build shows
      if (i < 27 && !tbl[i + 1].rst_before) begin
        chk($sformatf("tbl%0d_m0_en", i), 32'(en0), 32'(tbl[i + 1].exp_en));
        chk($sformatf("tbl%0d_m0_data", i), d0, tbl[i + 1].exp_data);
        chk($sformatf("tbl%0d_m0_addr_src", i), 32'({a0, s0}),
            32'({tbl[i + 1].exp_addr, tbl[i + 1].exp_src}));
      end
      step_advance(g);
    end

    // Reset right after an add transfer: the write is dropped, pointer returns to 0
    do_reset();
    vld = 4'b0010; dst[1] = 5'd8; res[1] = AD;
    step_sample(g); step_advance(g);
    vld = 4'b0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step_sample(g);
      chk("post_rst_no_wb_m1", 32'(en1), 32'd0);
      chk("post_rst_no_wb_m0", 32'(en0), 32'd0);
      step_advance(g);
    end
    vld = 4'b0011; dst[0] = 5'd3; res[0] = ML; dst[1] = 5'd3; res[1] = AD;
    step_sample(g);
    chk("post_rst_mult_first", 32'(rdy1), 32'h1);
    step_advance(g);
    vld[0] = 1'b0;
    step_sample(g);
    chk("post_rst_add_second", 32'(rdy1), 32'h2);
    step_advance(g);
    idle_steps(4);

    // Randomized traffic against the model, with one reset in the middle
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      for (int j = 0; j < 4; j++) begin
        if (!vld[j] && $urandom_range(0, 99) < 50) begin
          vld[j] = 1'b1;
          dst[j] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          res[j] = {$urandom, 3'($urandom_range(0, 7))};
          if ($urandom_range(0, 9) == 0) res[j][33:26] = 8'hFE;
          if ($urandom_range(0, 19) == 0) res[j][33:26] = 8'hFF;
        end
      end
      step_sample(g);
      step_advance(g);
      if (g >= 0) vld[g] = 1'b0;
    end
    idle_steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
